// File: rtl/tq_perm_pkg.sv
// Shared constants and the slot mapping for the 16-point even/odd permutation.
// The de-permute stage uses dst_idx to scatter each incoming coefficient.
package tq_perm_pkg;

    localparam int POINTS = 16;
    localparam int LANES  = 4;
    localparam int BEATS  = 4;

    // e=0 identity; m=0 undoes interleave (even sources to low half);
    // m=1 undoes de-interleave (low half to even slots).
    function automatic logic [3:0] dst_idx(input logic e, input logic m, input logic [3:0] src);
        logic [3:0] idx;
        if (!e) begin
            idx = src;
        end else if (!m) begin
            idx = {src[0], src[3:1]};
        end else begin
            idx = {src[2:0], src[3]};
        end
        return idx;
    endfunction

endpackage

// File: rtl/depremuat_bank.sv
// One 16-slot coefficient bank: four scattered write lanes, full-width parallel read.
module depremuat_bank
    import tq_perm_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [LANES-1:0]          wr_en,
    input  logic [LANES*4-1:0]        wr_idx,
    input  logic [LANES*WIDTH-1:0]    wr_data,
    output logic [POINTS*WIDTH-1:0]   rd_data
);

    logic [WIDTH-1:0] mem_q [POINTS];
    logic [WIDTH-1:0] mem_d [POINTS];

    always_comb begin
        mem_d = mem_q;
        for (int j = 0; j < LANES; j++) begin
            if (wr_en[j]) begin
                mem_d[wr_idx[4*j +: 4]] = wr_data[WIDTH*j +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < POINTS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < POINTS; i++) begin
            rd_data[WIDTH*i +: WIDTH] = mem_q[i];
        end
    end

endmodule

// File: rtl/depremuat1_16.sv
// 16-point de-permutation stage: four 4-lane beats in, one parallel vector out,
// with two ping-pong banks so the next vector fills while the last one waits.
module depremuat1_16
    import tq_perm_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      inverse,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*WIDTH-1:0]    in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [POINTS*WIDTH-1:0]   out_data
);

    logic [1:0] beat_q, beat_d;
    logic       wr_bank_q, wr_bank_d;
    logic       rd_bank_q, rd_bank_d;
    logic [1:0] full_q, full_d;
    logic       mode_e_q, mode_e_d;
    logic       mode_m_q, mode_m_d;

    logic                     accept;
    logic                     rd_fire;
    logic                     last_beat;
    logic                     cur_e;
    logic                     cur_m;
    logic [LANES*4-1:0]       lane_idx;
    logic [LANES-1:0]         wr_en0;
    logic [LANES-1:0]         wr_en1;
    logic [POINTS*WIDTH-1:0]  rd_data0;
    logic [POINTS*WIDTH-1:0]  rd_data1;

    assign in_ready  = !full_q[wr_bank_q];
    assign out_valid = full_q[rd_bank_q];
    assign accept    = in_valid && in_ready;
    assign rd_fire   = out_valid && out_ready;
    assign last_beat = (beat_q == 2'(BEATS - 1));

    // Beat 0 uses the live mode inputs; later beats use the copy latched at beat 0.
    assign cur_e = (beat_q == 2'd0) ? enable  : mode_e_q;
    assign cur_m = (beat_q == 2'd0) ? inverse : mode_m_q;

    always_comb begin
        lane_idx = '0;
        for (int j = 0; j < LANES; j++) begin
            lane_idx[4*j +: 4] = dst_idx(cur_e, cur_m, {beat_q, 2'(j)});
        end
    end

    assign wr_en0 = (accept && !wr_bank_q) ? '1 : '0;
    assign wr_en1 = (accept &&  wr_bank_q) ? '1 : '0;

    always_comb begin
        beat_d    = beat_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        full_d    = full_q;
        mode_e_d  = mode_e_q;
        mode_m_d  = mode_m_q;
        if (accept) begin
            beat_d = last_beat ? 2'd0 : beat_q + 2'd1;
            if (beat_q == 2'd0) begin
                mode_e_d = enable;
                mode_m_d = inverse;
            end
            if (last_beat) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
            end
        end
        // Never the same bank as the write above: in_ready is low when wr_bank is full.
        if (rd_fire) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = !rd_bank_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q    <= 2'd0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            full_q    <= 2'b00;
            mode_e_q  <= 1'b0;
            mode_m_q  <= 1'b0;
        end else begin
            beat_q    <= beat_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            full_q    <= full_d;
            mode_e_q  <= mode_e_d;
            mode_m_q  <= mode_m_d;
        end
    end

    depremuat_bank #(.WIDTH(WIDTH)) u_bank0 (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en0),
        .wr_idx  (lane_idx),
        .wr_data (in_data),
        .rd_data (rd_data0)
    );

    depremuat_bank #(.WIDTH(WIDTH)) u_bank1 (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en1),
        .wr_idx  (lane_idx),
        .wr_data (in_data),
        .rd_data (rd_data1)
    );

    assign out_data = rd_bank_q ? rd_data1 : rd_data0;

endmodule

// File: tb/tb_depremuat1_16.sv
// Scoreboard bench for depremuat1_16: expected vectors are queued when their last
// beat is accepted and popped when the DUT hands a vector out.
module tb_depremuat1_16;

    logic         clk;
    logic         rst;
    logic         enable;
    logic         inverse;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_data;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_data;

    int total;
    int bad;
    int cyc;
    int stalls;
    int popped;
    logic [255:0] exp_q[$];

    depremuat1_16 #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .inverse   (inverse),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [255:0] got, input logic [255:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%h want=%h", tag, got, want);
        end
    endtask

    // Reference de-permutation written straight from the mapping formulas.
    function automatic logic [255:0] modelVector(input logic [255:0] xv, input logic e, input logic m);
        logic [255:0] y;
        y = xv;
        if (e) begin
            for (int k = 0; k < 8; k++) begin
                if (!m) begin
                    y[16*k +: 16]     = xv[32*k +: 16];
                    y[16*(k+8) +: 16] = xv[16*(2*k+1) +: 16];
                end else begin
                    y[32*k +: 16]       = xv[16*k +: 16];
                    y[16*(2*k+1) +: 16] = xv[16*(k+8) +: 16];
                end
            end
        end
        return y;
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_out", 256'(1), 256'(0));
            end else begin
                checkOutput("out_data", out_data, exp_q.pop_front());
                popped++;
            end
        end
    end

    // Sends nbeats beats of xv; only a complete vector is pushed to the scoreboard.
    task automatic applyStimulus(input logic [255:0] xv, input logic e, input logic m,
                                 input bit toggle_mode, input bit ready_on_beat3,
                                 input bit check_latency, input int nbeats);
        bit acc;
        int guard;
        for (int b = 0; b < nbeats; b++) begin
            in_valid = 1'b1;
            in_data  = xv[64*b +: 64];
            enable   = (b == 0 || !toggle_mode) ? e : ~e;
            inverse  = (b == 0 || !toggle_mode) ? m : ~m;
            if (ready_on_beat3) out_ready = (b == 3);
            if (check_latency && b == 3) checkOutput("pre_latency_valid", 256'(out_valid), 256'(0));
            guard = 0;
            do begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                #1;
                guard++;
            end while (!acc && guard < 200);
            if (!acc) checkOutput("in_ready_timeout", 256'(0), 256'(1));
            stalls += guard - 1;
        end
        in_valid = 1'b0;
        if (nbeats == 4) begin
            exp_q.push_back(modelVector(xv, e, m));
            if (check_latency) checkOutput("latency_valid", 256'(out_valid), 256'(1));
        end
    endtask

    task automatic waitDrain(input string tag);
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
        checkOutput(tag, 256'(exp_q.size()), 256'(0));
        @(posedge clk);
        #1;
        checkOutput({tag, "_valid_low"}, 256'(out_valid), 256'(0));
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [255:0] ramp;
        logic [255:0] xv;
        logic [255:0] v1;
        logic [255:0] v2;
        logic [255:0] v3;
        int start;
        total = 0;
        bad = 0;
        stalls = 0;
        popped = 0;
        for (int i = 0; i < 16; i++) ramp[16*i +: 16] = 16'(i);

        rst = 1'b1;
        enable = 1'b0;
        inverse = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rst_in_ready", 256'(in_ready), 256'(1));
        checkOutput("rst_out_valid", 256'(out_valid), 256'(0));
        checkOutput("rst_out_data", out_data, 256'(0));

        $display("[TB] identity, undo interleave, undo de-interleave");
        out_ready = 1'b1;
        applyStimulus(ramp, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4);
        waitDrain("drain_identity");
        applyStimulus(ramp, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4);
        waitDrain("drain_interleave");
        applyStimulus(ramp, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 4);
        waitDrain("drain_deinterleave");

        $display("[TB] back-pressure with three vectors");
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            v1[16*i +: 16] = 16'(100 + i);
            v2[16*i +: 16] = 16'(200 + i);
            v3[16*i +: 16] = 16'(300 + i);
        end
        popped = 0;
        applyStimulus(v1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4);
        applyStimulus(v2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4);
        checkOutput("bp_in_ready_low", 256'(in_ready), 256'(0));
        checkOutput("bp_hold_data", out_data, modelVector(v1, 1'b1, 1'b0));
        repeat (3) @(posedge clk);
        #1;
        checkOutput("bp_hold_valid", 256'(out_valid), 256'(1));
        checkOutput("bp_hold_data_later", out_data, modelVector(v1, 1'b1, 1'b0));
        fork
            applyStimulus(v3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4);
            begin
                repeat (4) @(posedge clk);
                #1;
                checkOutput("bp_in_ready_stuck", 256'(in_ready), 256'(0));
                out_ready = 1'b1;
                @(posedge clk);
                #2;
                checkOutput("bp_in_ready_back", 256'(in_ready), 256'(1));
            end
        join
        waitDrain("drain_backpressure");
        checkOutput("bp_count", 256'(popped), 256'(3));

        $display("[TB] beat-3 accept coinciding with output handshake");
        stalls = 0;
        start = cyc;
        for (int v = 0; v < 10; v++) begin
            for (int i = 0; i < 8; i++) xv[32*i +: 32] = $urandom;
            applyStimulus(xv, (v % 3) != 0, (v % 3) == 2, 1'b0, 1'b1, 1'b0, 4);
        end
        checkOutput("tp_stalls", 256'(stalls), 256'(0));
        checkOutput("tp_cycles", 256'(cyc - start), 256'(40));
        out_ready = 1'b1;
        waitDrain("drain_throughput");

        $display("[TB] reset mid-vector");
        out_ready = 1'b0;
        applyStimulus(ramp, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4);
        applyStimulus(v1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        checkOutput("midrst_out_valid", 256'(out_valid), 256'(0));
        checkOutput("midrst_in_ready", 256'(in_ready), 256'(1));
        checkOutput("midrst_out_data", out_data, 256'(0));
        rst = 1'b0;
        out_ready = 1'b1;
        applyStimulus(v2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4);
        waitDrain("drain_after_reset");

        $display("[TB] signed extremes");
        for (int i = 0; i < 16; i++) xv[16*i +: 16] = (i % 2 == 0) ? 16'h8000 : 16'h7FFF;
        applyStimulus(xv, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4);
        applyStimulus(xv, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4);
        waitDrain("drain_extremes");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
